video_fetch_port: RTL and testbench
===================================

Name: video_fetch_port

Overview:
- Memory-side responder for the video read interface (vaddr/read/data) used by the shifter and Viking.
- Turns each accepted 64-bit video read into four sequential 16-bit reads on a narrow RAM port with a req/ack handshake.
- Assembles the four words into one 64-bit word and presents it on data.
- Sits between the video subsystem and the RAM arbiter, timed by the shared bus_cycle sequence.

Parameters:
TIMEOUT, 64, maximum cycles ram_req may stay high without ram_ack before the word is abandoned (must be ≥2).

Ports:
clk_32  in  1  system clock (31.875 MHz); all logic on rising edge
reset  in  1  synchronous, active-high reset
bus_cycle  in  2  CPU/video bus-cycle phase
vaddr  in  23  video word address from requester
read  in  1  video read request
data  out  64  assembled video data to requester
data_valid  out  1  one-cycle pulse when data is updated
busy  out  1  fetch in progress
overrun  out  1  sticky: request arrived while busy
timeout_err  out  1  sticky: at least one word timed out
ram_addr  out  23  16-bit word address to RAM
ram_req  out  1  RAM read request, held until acknowledged
ram_ack  in  1  RAM acknowledge; ram_din is valid in the same cycle
ram_din  in  16  RAM read data

Behaviour:
- Reset values:
  - data=0, data_valid=0, busy=0, overrun=0, timeout_err=0, ram_req=0, ram_addr=0.
  - Internal state is IDLE and bus_cycle history is 0.
- Accept condition (slot start):
  - read=1 AND bus_cycle==0 AND the registered previous bus_cycle!=0.
  - read held across a slot counts once.
- If the accept condition occurs outside IDLE:
  - The request is ignored.
  - overrun is set to 1 and stays set until reset.
- On accept in IDLE:
  - base={vaddr[22:2],2'b00} is latched; vaddr[1:0] is ignored.
  - Word index n=0 and busy=1 from the next cycle.
- States are IDLE, REQ, GAP, DONE.
- IDLE -> REQ on accept.
  - Next cycle: ram_req=1, ram_addr=base+n, timeout counter=0.
- In REQ:
  - On the edge where ram_ack=1, capture ram_din into slot n.
  - Slot 0 goes to data[63:48], slot 1 to [47:32], slot 2 to [31:16], slot 3 to [15:0] (big-endian; lowest address most significant).
  - ram_req then drops.
  - n<3: go to GAP. n==3: go to DONE.
- Timeout in REQ:
  - If TIMEOUT cycles of ram_req=1 elapse with no ram_ack, slot n is loaded with 16'hFFFF.
  - timeout_err is set and stays set until reset.
  - ram_req drops and the state advances exactly as on an ack.
- GAP lasts one cycle with ram_req=0, then n increments and the state returns to REQ.
  - ram_req therefore always shows a low cycle between words.
- DONE lasts one cycle:
  - data is loaded atomically from the four slots.
  - data_valid=1.
  - Next state is IDLE with busy=0.
- data holds its value between fetches and is never partially updated.
- Latency with zero-wait ack: data_valid is asserted exactly 8 cycles after the accept edge.
- ram_addr is stable while ram_req=1. Address arithmetic is mod 2^23; base is 4-aligned, so the address never wraps within a fetch.
- ram_ack while ram_req=0 is ignored.
- A timeout and an ack on the same edge are treated as an ack; the real data is used.
- reset mid-fetch:
  - The next edge returns to IDLE with ram_req=0 and all outputs at reset values.
  - Partial slots are discarded.
- Accept in the same cycle as DONE counts as overrun (busy is still 1).
- bus_cycle changing mid-fetch does not affect the fetch.

Test Plan:
- Zero-wait fetch:
  - Stimulus: ack always high; RAM returns addr[15:0]; vaddr=0x000104, read in slot.
  - Expect: ram_addr sequence 0x104, 0x105, 0x106, 0x107; data=0x0104_0105_0106_0107; data_valid one pulse 8 cycles after accept.
- Wait states:
  - Stimulus: ack delayed 3 cycles per word; vaddr=0x7FFFFE.
  - Expect: base 0x7FFFFC; four words in order; data_valid once; no timeout_err.
- Timeout:
  - Stimulus: no ack on word 2; TIMEOUT=64.
  - Expect: ram_req high for exactly 64 cycles on word 2; data[31:16]=0xFFFF, other slots correct; timeout_err=1.
- Overrun:
  - Stimulus: second slot-start with read=1 while busy.
  - Expect: overrun=1; first fetch completes unchanged; no second fetch.
- Read held over slots:
  - Stimulus: read high continuously over two separate bus_cycle 0 slots, with the fetch finishing in between.
  - Expect: exactly two fetches and two data_valid pulses.
- Reset during word 1 REQ:
  - Expect: next cycle ram_req=0, busy=0, data=0.
  - A later fetch works normally.

Source files
------------

// File: rtl/video_fetch_port.sv
// Video read responder: each accepted 64-bit video read is serviced as four
// sequential 16-bit RAM reads (req/ack), assembled big-endian and presented
// atomically on data with a one-cycle data_valid pulse.
module video_fetch_port #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_32,
  input  logic        reset,
  input  logic [1:0]  bus_cycle,
  input  logic [22:0] vaddr,
  input  logic        read,
  output logic [63:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  output logic [22:0] ram_addr,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic [15:0] ram_din
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        bc_prev_q, bc_prev_d;
  logic [22:0]       base_q, base_d;
  logic [1:0]        n_q, n_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [3:0][15:0]  slot_q, slot_d;
  logic [63:0]       data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic              overrun_q, overrun_d;
  logic              terr_q, terr_d;
  logic [22:0]       ram_addr_q, ram_addr_d;

  logic accept;
  logic word_done;

  // Next-state, word capture and output assembly
  always_comb begin
    state_d      = state_q;
    bc_prev_d    = bus_cycle;
    base_d       = base_q;
    n_d          = n_q;
    tmo_d        = tmo_q;
    slot_d       = slot_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    overrun_d    = overrun_q;
    terr_d       = terr_q;
    ram_addr_d   = ram_addr_q;
    word_done    = 1'b0;

    accept = read && (bus_cycle == 2'd0) && (bc_prev_q != 2'd0);

    if (accept && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d     = vaddr & 23'h7FFFFC;
          ram_addr_d = vaddr & 23'h7FFFFC;
          n_d        = 2'd0;
          tmo_d      = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // An ack on the timeout cycle wins: real data beats the filler.
        if (ram_ack) begin
          slot_d[n_q] = ram_din;
          word_done   = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          slot_d[n_q] = 16'hFFFF;
          terr_d      = 1'b1;
          word_done   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
        if (word_done) begin
          state_d = (n_q == 2'd3) ? DONE : GAP;
        end
      end
      GAP: begin
        n_d        = n_q + 2'd1;
        ram_addr_d = base_q + {21'd0, n_q + 2'd1};
        tmo_d      = '0;
        state_d    = REQ;
      end
      DONE: begin
        data_d       = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};
        data_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_32) begin
    if (reset) begin
      state_q      <= IDLE;
      bc_prev_q    <= '0;
      base_q       <= '0;
      n_q          <= '0;
      tmo_q        <= '0;
      slot_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      terr_q       <= 1'b0;
      ram_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      bc_prev_q    <= bc_prev_d;
      base_q       <= base_d;
      n_q          <= n_d;
      tmo_q        <= tmo_d;
      slot_q       <= slot_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      terr_q       <= terr_d;
      ram_addr_q   <= ram_addr_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = terr_q;
  assign ram_addr    = ram_addr_q;
  assign ram_req     = (state_q == REQ);

endmodule

// File: tb/tb_video_fetch_port.sv
// Bench for video_fetch_port: stimulus predicts each fetch from the slot and
// RAM-wait rules and queues expectations; a monitor compares DUT outputs.
module tb_video_fetch_port;

  localparam int unsigned TMO = 64;

  logic        clk_32 = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  bus_cycle = 2'd0;
  logic [22:0] vaddr = '0;
  logic        read = 1'b0;
  logic [63:0] data;
  logic        data_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [22:0] ram_addr;
  logic        ram_req;
  logic        ram_ack = 1'b0;
  logic [15:0] ram_din = '0;

  video_fetch_port #(.TIMEOUT(TMO)) dut (
    .clk_32(clk_32), .reset(reset), .bus_cycle(bus_cycle), .vaddr(vaddr),
    .read(read), .data(data), .data_valid(data_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .ram_addr(ram_addr),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_din(ram_din)
  );

  always #5 clk_32 = ~clk_32;

  int cyc_cnt = 0;
  always @(posedge clk_32) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] d;
    int          vld_edge;
    logic        terr;
  } exp_t;

  exp_t        sb_q[$];
  logic [22:0] addr_q[$];
  int          len_q[$];
  int          cur_waits[4];
  int          next_waits[4];
  int          busy_start = 1;
  int          busy_end = 0;
  int          ovr_edge = 0;
  logic        model_terr = 1'b0;
  logic [1:0]  prev_bc = 2'd0;
  int          last_e = 0;

  function automatic logic [15:0] mem(input logic [22:0] a);
    return a[15:0] ^ {9'd0, a[22:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, got, exp, cyc_cnt);
    end
  endtask

  // Predict a whole fetch accepted at edge e: RAM address order, request
  // lengths, assembled word and the edge where data_valid must appear.
  task automatic start_fetch(input int e, input logic [22:0] va);
    logic [22:0] base;
    logic [63:0] d;
    int          r;
    base = {va[22:2], 2'b00};
    d = '0;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      logic [22:0] a;
      logic [15:0] v;
      int          len;
      a = base + 23'(i);
      cur_waits[i] = next_waits[i];
      if (next_waits[i] < int'(TMO)) begin
        len = next_waits[i] + 1;
        v   = mem(a);
      end else begin
        len = int'(TMO);
        v   = 16'hFFFF;
        model_terr = 1'b1;
      end
      addr_q.push_back(a);
      len_q.push_back(len);
      r += len;
      d = {d[47:0], v};
    end
    sb_q.push_back('{d: d, vld_edge: e + r + 4, terr: model_terr});
    busy_start = e;
    busy_end   = e + r + 4;
    last_e     = e;
  endtask

  task automatic cyc(input logic [1:0] bc, input logic rd, input logic [22:0] va);
    int y;
    @(negedge clk_32);
    bus_cycle = bc;
    read = rd;
    vaddr = va;
    y = cyc_cnt + 1;
    if (rd && bc == 2'd0 && prev_bc != 2'd0) begin
      if (y <= busy_end) begin
        if (ovr_edge == 0) ovr_edge = y;
      end else begin
        start_fetch(y, va);
      end
    end
    prev_bc = bc;
  endtask

  task automatic slot(input int pad, input int zeros, input logic rd, input logic [22:0] va);
    for (int i = 0; i < pad; i++) cyc(2'(1 + (i % 3)), 1'($urandom_range(0, 1)), 23'($urandom));
    for (int i = 0; i < zeros; i++) cyc(2'd0, rd, va);
  endtask

  task automatic wait_idle();
    while (cyc_cnt <= busy_end + 2) cyc(2'd1, 1'b0, '0);
  endtask

  task automatic set_waits(input int w0, input int w1, input int w2, input int w3);
    next_waits[0] = w0; next_waits[1] = w1; next_waits[2] = w2; next_waits[3] = w3;
  endtask

  task automatic clear_model();
    sb_q.delete();
    addr_q.delete();
    len_q.delete();
    busy_start = 1;
    busy_end = 0;
    ovr_edge = 0;
    model_terr = 1'b0;
    prev_bc = 2'd0;
  endtask

  // RAM model: acks after the configured number of wait cycles per word,
  // and drives noise acks while no request is pending.
  initial begin
    int waited;
    waited = 0;
    forever begin
      @(negedge clk_32);
      if (reset) begin
        ram_ack = 1'b0;
        waited = 0;
      end else if (ram_req) begin
        if (waited >= cur_waits[ram_addr[1:0]]) begin
          ram_ack = 1'b1;
          ram_din = mem(ram_addr);
          waited = 0;
        end else begin
          ram_ack = 1'b0;
          ram_din = 16'($urandom);
          waited++;
        end
      end else begin
        waited = 0;
        ram_ack = 1'($urandom_range(0, 1));
        ram_din = 16'($urandom);
      end
    end
  end

  // Monitor: compares outputs against the queued predictions every cycle.
  initial begin
    logic        prev_req;
    logic [22:0] hold_addr;
    logic [63:0] last_data;
    int          run;
    exp_t        e;
    prev_req = 1'b0;
    hold_addr = '0;
    last_data = '0;
    run = 0;
    forever begin
      @(negedge clk_32);
      if (reset) begin
        prev_req = 1'b0;
        run = 0;
        last_data = '0;
      end else begin
        check("busy", busy, (cyc_cnt >= busy_start && cyc_cnt < busy_end));
        check("overrun", overrun, (ovr_edge != 0 && cyc_cnt >= ovr_edge));
        if (data_valid) begin
          if (sb_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("data", data, e.d);
            check("valid_edge", 64'(cyc_cnt), 64'(e.vld_edge));
            check("timeout_err", timeout_err, e.terr);
            last_data = e.d;
          end
        end else begin
          check("data_hold", data, last_data);
        end
        if (ram_req && !prev_req) begin
          run = 1;
          if (addr_q.size() == 0) check("unexpected_req", 1, 0);
          else check("ram_addr", ram_addr, addr_q.pop_front());
        end else if (ram_req && prev_req) begin
          run++;
          check("ram_addr_stable", ram_addr, hold_addr);
        end else if (!ram_req && prev_req) begin
          if (len_q.size() == 0) check("unexpected_req_len", 1, 0);
          else check("req_len", 64'(run), 64'(len_q.pop_front()));
        end
        prev_req = ram_req;
        hold_addr = ram_addr;
      end
    end
  end

  initial begin
    set_waits(0, 0, 0, 0);
    cur_waits = next_waits;
    // Reset values
    repeat (3) @(negedge clk_32);
    check("rst_data", data, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_ram_req", ram_req, 0);
    check("rst_ram_addr", ram_addr, 0);
    reset = 1'b0;

    // Zero-wait fetch
    set_waits(0, 0, 0, 0);
    slot(3, 1, 1'b1, 23'h000104);
    wait_idle();

    // Wait states, unaligned vaddr
    set_waits(3, 3, 3, 3);
    slot(3, 1, 1'b1, 23'h7FFFFE);
    wait_idle();
    check("no_timeout_err", timeout_err, 0);

    // Ack on the last allowed cycle, then a true timeout
    set_waits(63, 0, 64, 0);
    slot(5, 1, 1'b1, 23'h012340);
    wait_idle();

    // Timeout on word 2
    set_waits(0, 1, 255, 2);
    slot(2, 1, 1'b1, 23'h155557);
    wait_idle();
    check("timeout_sticky", timeout_err, 1);

    // Overrun: second slot start during a fetch
    set_waits(0, 0, 0, 0);
    slot(3, 1, 1'b1, 23'h000200);
    slot(3, 1, 1'b1, 23'h000300);
    wait_idle();
    check("overrun_sticky", overrun, 1);

    // Read held across two slots, second slot has two bus_cycle-0 cycles
    set_waits(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(2'(i + 1), 1'b1, 23'h001000);
    cyc(2'd0, 1'b1, 23'h001000);
    for (int i = 0; i < 14; i++) cyc(2'(1 + (i % 3)), 1'b1, 23'h001000);
    cyc(2'd0, 1'b1, 23'h002004);
    cyc(2'd0, 1'b1, 23'h002004);
    for (int i = 0; i < 14; i++) cyc(2'(1 + (i % 3)), 1'b1, 23'h002004);
    wait_idle();

    // Reset during word 1 request
    set_waits(0, 5, 0, 0);
    slot(3, 1, 1'b1, 23'h0ABC10);
    while (cyc_cnt < last_e + 3) @(negedge clk_32);
    check("pre_rst_req", ram_req, 1);
    check("pre_rst_addr", ram_addr, 23'h0ABC11);
    reset = 1'b1;
    read = 1'b0;
    bus_cycle = 2'd0;
    clear_model();
    @(negedge clk_32);
    check("mid_rst_ram_req", ram_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_overrun", overrun, 0);
    @(negedge clk_32);
    reset = 1'b0;
    prev_bc = 2'd0;

    // Fetch after reset
    set_waits(0, 0, 0, 0);
    slot(3, 1, 1'b1, 23'h3C0F0B);
    wait_idle();

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0)
          next_waits[i] = ($urandom_range(0, 1) == 1) ? 255 : int'($urandom_range(60, 66));
        else
          next_waits[i] = int'($urandom_range(0, 4));
      end
      slot(int'($urandom_range(1, 10)), int'($urandom_range(1, 2)),
           1'($urandom_range(0, 3) != 0), 23'($urandom));
    end
    wait_idle();

    check("sb_drain", 64'(sb_q.size()), 0);
    check("addr_drain", 64'(addr_q.size()), 0);
    check("len_drain", 64'(len_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
